// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared constants, read-mux selects and FSM states for the parity error monitor
package parity_pkg;

    localparam int MXCFEB = 5;
    localparam int MXRAM  = 37;
    localparam int CNTB   = 16;
    localparam int BXB    = 12;
    localparam int NCNT   = 8;

    localparam logic [2:0] SEL_TOTAL = 3'd0;
    localparam logic [2:0] SEL_CFEB0 = 3'd1;
    localparam logic [2:0] SEL_RPC   = 3'd6;
    localparam logic [2:0] SEL_MINI  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } perr_state_t;

endpackage

// File: rtl/perr_sat_counter.sv
// rtl/perr_sat_counter.sv - W-bit saturating event counter with synchronous clear
module perr_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parity_err_monitor.sv
// rtl/parity_err_monitor.sv - parity error counters, VME read mux and first-error snapshot with IRQ
// Optional PERR_EDGE_COUNT_EN: per-source counters count rising edges instead of high cycles.
module parity_err_monitor #(
    parameter int MXCFEB = parity_pkg::MXCFEB,
    parameter int MXRAM  = parity_pkg::MXRAM,
    parameter int CNTB   = parity_pkg::CNTB,
    parameter int BXB    = parity_pkg::BXB
) (
    input  logic              clock,
    input  logic              global_reset_n,
    input  logic              perr_reset,
    input  logic              perr_en,
    input  logic [MXCFEB-1:0] perr_cfeb,
    input  logic              perr_rpc,
    input  logic              perr_mini,
    input  logic              perr_pulse,
    input  logic [MXRAM-1:0]  perr_ram_ff,
    input  logic [BXB-1:0]    bx_cnt,
    input  logic              irq_ack,
    input  logic [2:0]        vme_sel,
    output logic [CNTB-1:0]   vme_rd_data,
    output logic              perr_cnt_sat,
    output logic              perr_first_vld,
    output logic [BXB-1:0]    perr_first_bx,
    output logic [MXRAM-1:0]  perr_first_ram,
    output logic              perr_irq
);

    import parity_pkg::*;

    logic [NCNT-1:0] src_raw;
    logic [NCNT-1:0] inc;
    logic [NCNT-1:0] at_max;
    logic [CNTB-1:0] cnt [NCNT];

    perr_state_t      state_q, state_d;
    logic [CNTB-1:0]  vme_rd_data_q, vme_rd_data_d;
    logic             perr_cnt_sat_q, perr_cnt_sat_d;
    logic             perr_first_vld_q, perr_first_vld_d;
    logic [BXB-1:0]   perr_first_bx_q, perr_first_bx_d;
    logic [MXRAM-1:0] perr_first_ram_q, perr_first_ram_d;
    logic             perr_irq_q, perr_irq_d;

    // The total counter follows perr_pulse directly; it is already gated upstream.
    always_comb begin
        src_raw = '0;
        src_raw[SEL_TOTAL] = perr_pulse;
        for (int i = 0; i < MXCFEB; i++) begin
            src_raw[int'(SEL_CFEB0) + i] = perr_en & perr_cfeb[i];
        end
        src_raw[SEL_RPC]  = perr_en & perr_rpc;
        src_raw[SEL_MINI] = perr_en & perr_mini;
    end

`ifdef PERR_EDGE_COUNT_EN
    logic [NCNT-1:1] src_dly_q, src_dly_d;

    always_comb begin
        src_dly_d = perr_reset ? '0 : src_raw[NCNT-1:1];
        inc       = {src_raw[NCNT-1:1] & ~src_dly_q, src_raw[0]};
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            src_dly_q <= '0;
        end else begin
            src_dly_q <= src_dly_d;
        end
    end
`else
    assign inc = src_raw;
`endif

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        perr_sat_counter #(.W(CNTB)) u_cnt (
            .clk    (clock),
            .rst_n  (global_reset_n),
            .clr    (perr_reset),
            .inc    (inc[g]),
            .cnt    (cnt[g]),
            .at_max (at_max[g])
        );
    end

    always_comb begin
        state_d          = state_q;
        vme_rd_data_d    = cnt[vme_sel];
        perr_cnt_sat_d   = perr_cnt_sat_q | (|at_max);
        perr_first_vld_d = perr_first_vld_q;
        perr_first_bx_d  = perr_first_bx_q;
        perr_first_ram_d = perr_first_ram_q;
        perr_irq_d       = perr_irq_q;

        if (perr_reset) begin
            state_d          = IDLE;
            vme_rd_data_d    = '0;
            perr_cnt_sat_d   = 1'b0;
            perr_first_vld_d = 1'b0;
            perr_first_bx_d  = '0;
            perr_first_ram_d = '0;
            perr_irq_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (perr_en) state_d = ARMED;
                end
                // A pulse takes priority over perr_en dropping in the same cycle.
                ARMED: begin
                    if (perr_pulse) begin
                        state_d          = HELD;
                        perr_first_vld_d = 1'b1;
                        perr_first_bx_d  = bx_cnt;
                        perr_first_ram_d = perr_ram_ff;
                        perr_irq_d       = 1'b1;
                    end else if (!perr_en) begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (irq_ack) perr_irq_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q          <= IDLE;
            vme_rd_data_q    <= '0;
            perr_cnt_sat_q   <= 1'b0;
            perr_first_vld_q <= 1'b0;
            perr_first_bx_q  <= '0;
            perr_first_ram_q <= '0;
            perr_irq_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            vme_rd_data_q    <= vme_rd_data_d;
            perr_cnt_sat_q   <= perr_cnt_sat_d;
            perr_first_vld_q <= perr_first_vld_d;
            perr_first_bx_q  <= perr_first_bx_d;
            perr_first_ram_q <= perr_first_ram_d;
            perr_irq_q       <= perr_irq_d;
        end
    end

    assign vme_rd_data    = vme_rd_data_q;
    assign perr_cnt_sat   = perr_cnt_sat_q;
    assign perr_first_vld = perr_first_vld_q;
    assign perr_first_bx  = perr_first_bx_q;
    assign perr_first_ram = perr_first_ram_q;
    assign perr_irq       = perr_irq_q;

endmodule

// File: tb/tb_parity_err_monitor.sv
// tb/tb_parity_err_monitor.sv - randomized and directed bench for parity_err_monitor against a behavioural model
module tb_parity_err_monitor;

    localparam int CNTB_TB = 10;
    localparam int MAXV    = (1 << CNTB_TB) - 1;

    logic                clock = 1'b0;
    logic                global_reset_n;
    logic                perr_reset;
    logic                perr_en;
    logic [4:0]          perr_cfeb;
    logic                perr_rpc;
    logic                perr_mini;
    logic                perr_pulse;
    logic [36:0]         perr_ram_ff;
    logic [11:0]         bx_cnt;
    logic                irq_ack;
    logic [2:0]          vme_sel;
    logic [CNTB_TB-1:0]  vme_rd_data;
    logic                perr_cnt_sat;
    logic                perr_first_vld;
    logic [11:0]         perr_first_bx;
    logic [36:0]         perr_first_ram;
    logic                perr_irq;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int       exp_cnt [8];
    bit       prev_src [8];
    bit       m_armed, m_held;
    bit       exp_vld, exp_irq, exp_sat;
    bit [11:0] exp_bx;
    bit [36:0] exp_ram;
    int       exp_rd;

    always #5 clock = ~clock;

    parity_err_monitor #(.MXCFEB(5), .MXRAM(37), .CNTB(CNTB_TB), .BXB(12)) dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .perr_reset     (perr_reset),
        .perr_en        (perr_en),
        .perr_cfeb      (perr_cfeb),
        .perr_rpc       (perr_rpc),
        .perr_mini      (perr_mini),
        .perr_pulse     (perr_pulse),
        .perr_ram_ff    (perr_ram_ff),
        .bx_cnt         (bx_cnt),
        .irq_ack        (irq_ack),
        .vme_sel        (vme_sel),
        .vme_rd_data    (vme_rd_data),
        .perr_cnt_sat   (perr_cnt_sat),
        .perr_first_vld (perr_first_vld),
        .perr_first_bx  (perr_first_bx),
        .perr_first_ram (perr_first_ram),
        .perr_irq       (perr_irq)
    );

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            exp_cnt[i]  = 0;
            prev_src[i] = 1'b0;
        end
        m_armed = 0; m_held = 0;
        exp_vld = 0; exp_irq = 0; exp_sat = 0;
        exp_bx = '0; exp_ram = '0; exp_rd = 0;
    endtask

    task automatic model_update();
        bit src [8];
        bit hit, any_max;
        if (!global_reset_n || perr_reset) begin
            model_clear();
        end else begin
            any_max = 0;
            for (int i = 0; i < 8; i++) if (exp_cnt[i] == MAXV) any_max = 1;
            exp_sat = exp_sat | any_max;
            exp_rd  = exp_cnt[vme_sel];
            src[0] = perr_pulse;
            for (int i = 0; i < 5; i++) src[i+1] = perr_en && perr_cfeb[i];
            src[6] = perr_en && perr_rpc;
            src[7] = perr_en && perr_mini;
            for (int i = 0; i < 8; i++) begin
                hit = src[i];
`ifdef PERR_EDGE_COUNT_EN
                if (i > 0) hit = src[i] && !prev_src[i];
`endif
                if (hit && exp_cnt[i] < MAXV) exp_cnt[i]++;
                prev_src[i] = src[i];
            end
            if (m_held) begin
                if (irq_ack) exp_irq = 0;
            end else if (m_armed) begin
                if (perr_pulse) begin
                    m_held = 1; m_armed = 0;
                    exp_vld = 1; exp_irq = 1;
                    exp_bx = bx_cnt; exp_ram = perr_ram_ff;
                end else if (!perr_en) begin
                    m_armed = 0;
                end
            end else if (perr_en) begin
                m_armed = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic drive_quiet();
        perr_reset = 0; perr_en = 0; perr_cfeb = '0; perr_rpc = 0; perr_mini = 0;
        perr_pulse = 0; perr_ram_ff = '0; bx_cnt = '0; irq_ack = 0; vme_sel = '0;
    endtask

    task automatic do_perr_reset();
        drive_quiet();
        perr_reset = 1;
        tick();
        perr_reset = 0;
    endtask

    task automatic test_reset();
        global_reset_n = 0;
        drive_quiet();
        model_clear();
        tick();
        tick();
        global_reset_n = 1;
        n_vec++; if (vme_rd_data !== '0) begin n_err++; $display("FAIL reset_rd got %0d want 0", vme_rd_data); end
        n_vec++; if (perr_cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %0b want 0", perr_cnt_sat); end
        n_vec++; if (perr_first_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %0b want 0", perr_first_vld); end
        n_vec++; if (perr_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %0b want 0", perr_irq); end
        perr_en = 1;
        for (int i = 0; i < 5; i++) begin
            perr_pulse = 1; bx_cnt = 12'(i); perr_ram_ff = 37'(i + 1);
            tick();
        end
        perr_pulse = 0;
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(5)) begin n_err++; $display("FAIL pre_async_rd got %0d want 5", vme_rd_data); end
        #2 global_reset_n = 0;
        model_clear();
        #1;
        n_vec++; if (vme_rd_data !== '0) begin n_err++; $display("FAIL async_rd got %0d want 0", vme_rd_data); end
        n_vec++; if (perr_first_vld !== 1'b0 || perr_irq !== 1'b0) begin
            n_err++; $display("FAIL async_flags got vld=%0b irq=%0b want 0 0", perr_first_vld, perr_irq); end
        n_vec++; if (perr_first_bx !== '0 || perr_first_ram !== '0) begin
            n_err++; $display("FAIL async_snap got bx=%h ram=%h want 0 0", perr_first_bx, perr_first_ram); end
        drive_quiet();
        tick();
        global_reset_n = 1;
    endtask

    task automatic test_single_error();
        do_perr_reset();
        perr_en = 1;
        tick();
        perr_cfeb = 5'b00100;
        tick();
        perr_cfeb = '0; perr_pulse = 1; perr_ram_ff = 37'h0_0000_1000; bx_cnt = 12'h123;
        tick();
        perr_pulse = 0; perr_ram_ff = 37'h1f_ffff_ffff; bx_cnt = 12'h124; vme_sel = 3'd3;
        n_vec++; if (perr_first_bx !== 12'h123) begin n_err++; $display("FAIL first_bx got %h want 123", perr_first_bx); end
        n_vec++; if (perr_first_ram !== 37'h0_0000_1000) begin n_err++; $display("FAIL first_ram got %h want 1000", perr_first_ram); end
        n_vec++; if (perr_first_vld !== 1'b1) begin n_err++; $display("FAIL first_vld got %0b want 1", perr_first_vld); end
        n_vec++; if (perr_irq !== 1'b1) begin n_err++; $display("FAIL first_irq got %0b want 1", perr_irq); end
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(1)) begin n_err++; $display("FAIL cnt3 got %0d want 1", vme_rd_data); end
        n_vec++; if (perr_first_ram !== 37'h0_0000_1000) begin n_err++; $display("FAIL ram_hold got %h want 1000", perr_first_ram); end
        vme_sel = 3'd0;
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(1)) begin n_err++; $display("FAIL cnt0 got %0d want 1", vme_rd_data); end
    endtask

    task automatic test_second_error();
        perr_pulse = 1; bx_cnt = 12'h200; perr_ram_ff = 37'h0_0000_0001;
        tick();
        perr_pulse = 0;
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(2)) begin n_err++; $display("FAIL cnt0_second got %0d want 2", vme_rd_data); end
        n_vec++; if (perr_first_bx !== 12'h123) begin n_err++; $display("FAIL bx_held got %h want 123", perr_first_bx); end
    endtask

    task automatic test_irq();
        irq_ack = 1;
        tick();
        irq_ack = 0;
        n_vec++; if (perr_irq !== 1'b0) begin n_err++; $display("FAIL irq_ack got %0b want 0", perr_irq); end
        n_vec++; if (perr_first_vld !== 1'b1) begin n_err++; $display("FAIL vld_after_ack got %0b want 1", perr_first_vld); end
        do_perr_reset();
        n_vec++; if (perr_first_vld !== 1'b0 || perr_first_bx !== '0 || perr_first_ram !== '0) begin
            n_err++; $display("FAIL perr_reset_snap got vld=%0b bx=%h ram=%h want 0", perr_first_vld, perr_first_bx, perr_first_ram); end
        perr_pulse = 1; bx_cnt = 12'h055;
        tick();
        perr_pulse = 0;
        n_vec++; if (perr_first_vld !== 1'b0) begin n_err++; $display("FAIL idle_pulse got vld=%0b want 0", perr_first_vld); end
        perr_en = 1;
        tick();
        perr_pulse = 1; irq_ack = 1; bx_cnt = 12'h077;
        tick();
        perr_pulse = 0; irq_ack = 0;
        n_vec++; if (perr_irq !== 1'b1) begin n_err++; $display("FAIL ack_vs_set got irq=%0b want 1", perr_irq); end
    endtask

    task automatic test_saturation();
        do_perr_reset();
        perr_en = 1; vme_sel = 3'd6;
        for (int i = 0; i < 1100; i++) begin
            perr_rpc = 1; tick();
            perr_rpc = 0; tick();
        end
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(MAXV)) begin n_err++; $display("FAIL rpc_sat got %0d want %0d", vme_rd_data, MAXV); end
        n_vec++; if (perr_cnt_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag got %0b want 1", perr_cnt_sat); end
        perr_rpc = 1; perr_pulse = 1;
        tick();
        perr_rpc = 0; perr_pulse = 0;
        tick();
        n_vec++; if (vme_rd_data !== CNTB_TB'(MAXV)) begin n_err++; $display("FAIL rpc_no_wrap got %0d want %0d", vme_rd_data, MAXV); end
        n_vec++; if (perr_cnt_sat !== exp_sat) begin n_err++; $display("FAIL sat_sticky got %0b want %0b", perr_cnt_sat, exp_sat); end
    endtask

    task automatic test_edge_count();
        do_perr_reset();
        perr_en = 1;
        perr_mini = 1;
        repeat (10) tick();
        perr_mini = 0; vme_sel = 3'd7;
        tick();
        tick();
`ifdef PERR_EDGE_COUNT_EN
        n_vec++; if (vme_rd_data !== CNTB_TB'(1)) begin n_err++; $display("FAIL mini_edge got %0d want 1", vme_rd_data); end
`else
        n_vec++; if (vme_rd_data !== CNTB_TB'(10)) begin n_err++; $display("FAIL mini_level got %0d want 10", vme_rd_data); end
`endif
    endtask

    task automatic test_random();
        do_perr_reset();
        for (int c = 0; c < 600; c++) begin
            perr_reset  = ($urandom_range(0, 99) == 0);
            perr_en     = ($urandom_range(0, 9) != 0);
            perr_cfeb   = 5'($urandom) & 5'($urandom) & 5'($urandom);
            perr_rpc    = ($urandom_range(0, 3) == 0);
            perr_mini   = ($urandom_range(0, 3) == 0);
            perr_pulse  = ($urandom_range(0, 7) == 0);
            perr_ram_ff = {5'($urandom), 32'($urandom)};
            bx_cnt      = 12'($urandom);
            irq_ack     = ($urandom_range(0, 15) == 0);
            vme_sel     = 3'($urandom);
            tick();
            n_vec++; if (vme_rd_data !== CNTB_TB'(exp_rd)) begin n_err++; $display("FAIL rnd_rd c=%0d got %0d want %0d", c, vme_rd_data, exp_rd); end
            n_vec++; if (perr_cnt_sat !== exp_sat) begin n_err++; $display("FAIL rnd_sat c=%0d got %0b want %0b", c, perr_cnt_sat, exp_sat); end
            n_vec++; if (perr_first_vld !== exp_vld) begin n_err++; $display("FAIL rnd_vld c=%0d got %0b want %0b", c, perr_first_vld, exp_vld); end
            n_vec++; if (perr_first_bx !== exp_bx) begin n_err++; $display("FAIL rnd_bx c=%0d got %h want %h", c, perr_first_bx, exp_bx); end
            n_vec++; if (perr_first_ram !== exp_ram) begin n_err++; $display("FAIL rnd_ram c=%0d got %h want %h", c, perr_first_ram, exp_ram); end
            n_vec++; if (perr_irq !== exp_irq) begin n_err++; $display("FAIL rnd_irq c=%0d got %0b want %0b", c, perr_irq, exp_irq); end
        end
        drive_quiet();
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_second_error();
        test_irq();
        test_saturation();
        test_edge_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
